// File: rtl/down_counter4b.sv
// down_counter4b: 4-bit synchronous down counter with parallel load,
// cascade borrow chain (Ci -> Bc) and a sticky underflow flag.
// Counts MAX..0 and wraps to MAX, where MAX is 15 (binary) or 9 (BCD).
// Build option: define DOWN_COUNTER4B_BCD_EN for BCD mode.
//   - MAX becomes 9.
//   - Load values above 9 are clamped to 9.
//   - Without the macro the counter is plain binary and every load value is accepted.
module down_counter4b (
    input  logic clk,
    input  logic rst_n,
    input  logic Ld,
    input  logic Da,
    input  logic Db,
    input  logic Dc,
    input  logic Dd,
    input  logic En,
    input  logic Ci,
    output logic Qa,
    output logic Qb,
    output logic Qc,
    output logic Qd,
    output logic Bc,
    output logic Uf
);

`ifdef DOWN_COUNTER4B_BCD_EN
    localparam logic [3:0] MAX = 4'd9;
`else
    localparam logic [3:0] MAX = 4'd15;
`endif

    logic [3:0] r_q;
    logic       r_uf;

    logic [3:0] w_d;
    logic [3:0] w_load_val;
    logic [3:0] w_dec_val;
    logic       w_zero;
    logic       w_dec;

    assign w_d    = {Dd, Dc, Db, Da};
    assign w_zero = (r_q == 4'd0);
    // The counter decrements only while enabled and the lower stage borrows.
    assign w_dec  = En & Ci;

    // Select the value a load writes; in BCD mode out-of-range digits saturate at 9.
    always_comb begin
        w_load_val = w_d;
`ifdef DOWN_COUNTER4B_BCD_EN
        if (w_d > MAX) begin
            w_load_val = MAX;
        end
`endif
    end

    // Select the next count on a decrement: step down, or wrap from 0 to MAX.
    always_comb begin
        w_dec_val = r_q - 4'd1;
        if (w_zero) begin
            w_dec_val = MAX;
        end
    end

    // Count and underflow state. Priority: reset, then load, then decrement, then hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q  <= MAX;
            r_uf <= 1'b0;
        end else if (Ld) begin
            r_q  <= w_load_val;
            r_uf <= 1'b0;
        end else if (w_dec) begin
            r_q  <= w_dec_val;
            r_uf <= r_uf | w_zero;
        end
    end

    assign {Qd, Qc, Qb, Qa} = r_q;
    // Borrow-out is combinational so a cascaded stage sees it in the same cycle.
    assign Bc = w_zero & Ci;
    assign Uf = r_uf;

endmodule

// File: tb/tb_down_counter4b.sv
// tb_down_counter4b: directed bench for down_counter4b with a behavioural model.
// One standalone stage plus a two-stage cascade are checked every cycle.
module tb_down_counter4b;

`ifdef DOWN_COUNTER4B_BCD_EN
    localparam int MAX = 9;
`else
    localparam int MAX = 15;
`endif
    localparam int RAD = MAX + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Standalone stage stimulus
    logic       ld = 1'b0, en = 1'b0, ci = 1'b1;
    logic [3:0] d  = 4'd0;
    logic       qa, qb, qc, qd, bc, uf;
    logic [3:0] q;
    assign q = {qd, qc, qb, qa};

    down_counter4b u_dut (
        .clk(clk), .rst_n(rst_n), .Ld(ld),
        .Da(d[0]), .Db(d[1]), .Dc(d[2]), .Dd(d[3]),
        .En(en), .Ci(ci),
        .Qa(qa), .Qb(qb), .Qc(qc), .Qd(qd), .Bc(bc), .Uf(uf)
    );

    // Cascade stimulus
    logic       c_ld = 1'b0, c_en = 1'b0;
    logic [3:0] c_dlo = 4'd0, c_dhi = 4'd0;
    logic       lqa, lqb, lqc, lqd, lbc, luf;
    logic       hqa, hqb, hqc, hqd, hbc, huf;
    logic [3:0] lq, hq;
    assign lq = {lqd, lqc, lqb, lqa};
    assign hq = {hqd, hqc, hqb, hqa};

    down_counter4b u_lo (
        .clk(clk), .rst_n(rst_n), .Ld(c_ld),
        .Da(c_dlo[0]), .Db(c_dlo[1]), .Dc(c_dlo[2]), .Dd(c_dlo[3]),
        .En(c_en), .Ci(1'b1),
        .Qa(lqa), .Qb(lqb), .Qc(lqc), .Qd(lqd), .Bc(lbc), .Uf(luf)
    );

    down_counter4b u_hi (
        .clk(clk), .rst_n(rst_n), .Ld(c_ld),
        .Da(c_dhi[0]), .Db(c_dhi[1]), .Dc(c_dhi[2]), .Dd(c_dhi[3]),
        .En(c_en), .Ci(lbc),
        .Qa(hqa), .Qb(hqb), .Qc(hqc), .Qd(hqd), .Bc(hbc), .Uf(huf)
    );

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clampv(input int v);
        return (v > MAX) ? MAX : v;
    endfunction

    // Behavioural model: single stage as an integer in 0..MAX
    int m_q  = MAX;
    int m_uf = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q = MAX; m_uf = 0;
        end else if (ld) begin
            m_q = clampv(int'(d)); m_uf = 0;
        end else if (en && ci) begin
            if (m_q == 0) m_uf = 1;
            m_q = (m_q + MAX) % RAD;
        end
    end

    // Behavioural model: cascade as one integer in 0..RAD*RAD-1
    int m_n   = MAX * RAD + MAX;
    int m_luf = 0;
    int m_huf = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n = MAX * RAD + MAX; m_luf = 0; m_huf = 0;
        end else if (c_ld) begin
            m_n = clampv(int'(c_dhi)) * RAD + clampv(int'(c_dlo));
            m_luf = 0; m_huf = 0;
        end else if (c_en) begin
            if (m_n % RAD == 0) m_luf = 1;
            if (m_n == 0)       m_huf = 1;
            m_n = (m_n + RAD * RAD - 1) % (RAD * RAD);
        end
    end

    // Per-cycle compare, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("q",      int'(q),   m_q);
            check("uf",     int'(uf),  m_uf);
            check("bc",     int'(bc),  (m_q == 0 && ci) ? 1 : 0);
            check("c_lo_q", int'(lq),  m_n % RAD);
            check("c_hi_q", int'(hq),  m_n / RAD);
            check("c_luf",  int'(luf), m_luf);
            check("c_huf",  int'(huf), m_huf);
            check("c_hbc",  int'(hbc), (m_n == 0) ? 1 : 0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    typedef struct packed {
        logic       ld;
        logic       en;
        logic       ci;
        logic [3:0] d;
    } vec_t;

    vec_t vecs [10];

    initial begin
        // Reset and release
        tick(2);
        rst_n = 1'b1;
        check("rst_q",  int'(q),  MAX);
        check("rst_uf", int'(uf), 0);
        check("rst_bc", int'(bc), 0);
        chk_en = 1'b1;

        // Free count down to 0, then wrap
        en = 1'b1; ci = 1'b1;
        tick(MAX);
        check("free_q0",   int'(q),  0);
        check("free_bc0",  int'(bc), 1);
        check("free_uf0",  int'(uf), 0);
        tick(1);
        check("wrap_q",    int'(q),  MAX);
        check("wrap_uf",   int'(uf), 1);
        check("wrap_bc",   int'(bc), 0);

        // Load wins over a simultaneous wrap and clears Uf
        tick(MAX);
        check("pre_ld_q", int'(q), 0);
        ld = 1'b1; d = 4'b0101;
        tick(1);
        check("ld_pri_q",  int'(q),  5);
        check("ld_pri_uf", int'(uf), 0);

        // Hold at 0011 with En=0, then with Ci=0
        d = 4'b0011;
        tick(1);
        ld = 1'b0; en = 1'b0;
        tick(5);
        check("hold_en_q",  int'(q),  3);
        check("hold_en_bc", int'(bc), 0);
        en = 1'b1; ci = 1'b0;
        tick(5);
        check("hold_ci_q",  int'(q),  3);

        // Load 0: Bc follows in the cycle after the load edge, masked by Ci
        ld = 1'b1; d = 4'b0000; ci = 1'b1;
        tick(1);
        ld = 1'b0; en = 1'b0;
        #1;
        check("ld0_bc",  int'(bc), 1);
        ci = 1'b0;
        #1;
        check("ci0_bc",  int'(bc), 0);
        en = 1'b1;
        tick(2);
        check("ci0_hold_q", int'(q), 0);

        // Sticky underflow across a second wrap
        ci = 1'b1;
        tick(1);
        check("stk_uf1", int'(uf), 1);
        tick(RAD);
        check("stk_uf2", int'(uf), 1);
        check("stk_q",   int'(q),  MAX);

        // Async reset mid-count with a pending load
        tick(3);
        rst_n = 1'b0; ld = 1'b1; d = 4'b0111;
        #1;
        check("arst_q",  int'(q),  MAX);
        check("arst_uf", int'(uf), 0);
        check("arst_bc", int'(bc), 0);
        tick(1);
        check("arst_hold_q", int'(q), MAX);
        rst_n = 1'b1; ld = 1'b0; en = 1'b0;
        tick(1);
        check("rel_q", int'(q), MAX);

        // Oversized load value (clamped in BCD mode)
        ld = 1'b1; d = 4'b1100;
        tick(1);
        check("ld_big_q", int'(q), clampv(12));
        ld = 1'b0;

        // Directed vector table, checked by the model every cycle
        vecs[0] = '{ld:1'b1, en:1'b0, ci:1'b1, d:4'd9};
        vecs[1] = '{ld:1'b0, en:1'b1, ci:1'b1, d:4'd0};
        vecs[2] = '{ld:1'b0, en:1'b1, ci:1'b0, d:4'd0};
        vecs[3] = '{ld:1'b0, en:1'b0, ci:1'b1, d:4'd2};
        vecs[4] = '{ld:1'b1, en:1'b1, ci:1'b0, d:4'd1};
        vecs[5] = '{ld:1'b0, en:1'b1, ci:1'b1, d:4'd0};
        vecs[6] = '{ld:1'b0, en:1'b1, ci:1'b1, d:4'd0};
        vecs[7] = '{ld:1'b1, en:1'b1, ci:1'b1, d:4'd15};
        vecs[8] = '{ld:1'b0, en:1'b1, ci:1'b1, d:4'd0};
        vecs[9] = '{ld:1'b0, en:1'b0, ci:1'b0, d:4'd0};
        for (int i = 0; i < 10; i++) begin
            ld = vecs[i].ld; en = vecs[i].en; ci = vecs[i].ci; d = vecs[i].d;
            tick(1);
        end
        // Last vector held: 15 (or 9) loaded, one decrement
        check("vec_end_q", int'(q), clampv(15) - 1);
        ld = 1'b0; en = 1'b0; ci = 1'b1;

        // Cascade: load 8'h10 then count
        c_ld = 1'b1; c_dhi = 4'd1; c_dlo = 4'd0; c_en = 1'b1;
        tick(1);
        check("cas_ld_hi", int'(hq), 1);
        check("cas_ld_lo", int'(lq), 0);
        c_ld = 1'b0;
        tick(1);
        check("cas_1_hi", int'(hq), 0);
        check("cas_1_lo", int'(lq), MAX);
        check("cas_1_luf", int'(luf), 1);
        tick(MAX + 1);
        check("cas_ff_hi",  int'(hq),  MAX);
        check("cas_ff_lo",  int'(lq),  MAX);
        check("cas_ff_luf", int'(luf), 1);
        check("cas_ff_huf", int'(huf), 1);
        c_en = 1'b0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
